matrix_row_store: RTL and testbench



---
 rtl/matrix_row_store.sv | 233 +++++++++++++++++++++++
 tb/tb_matrix_row_store.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_store.sv
// Row-memory responder for the lu / triang_matrix_inv engines: working, L and U banks,
// host load/unload and an L/U -> working copy sequencer. Macro: ROW_STORE_TRANSPOSE_EN.
module matrix_row_store #(
    parameter  int unsigned SIZE  = 4,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned AW    = $clog2(SIZE),
    localparam int unsigned EW    = 2 * WIDTH,
    localparam int unsigned RW    = SIZE * EW
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_addr_valid_i,
    output logic [RW-1:0] rd_row_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_valid_o,

    input  logic [RW-1:0] wr_row_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,

    input  logic [RW-1:0] l_col_i,
    input  logic [RW-1:0] u_row_i,
    input  logic [AW-1:0] res_addr_i,
    input  logic          res_valid_i,
    output logic          res_ready_o,

    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [1:0]    host_sel_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [RW-1:0] host_wdata_i,
    output logic          host_ready_o,
    output logic [RW-1:0] host_rdata_o,
    output logic          host_rvalid_o,

    input  logic          copy_start_i,
    input  logic          copy_src_i,
    input  logic          copy_transpose_i,
    output logic          busy_o,
    output logic          err_o
);

    localparam logic [1:0] SEL_WORK = 2'd0;
    localparam logic [1:0] SEL_L    = 2'd1;
    localparam logic [1:0] SEL_U    = 2'd2;

    typedef enum logic {
        S_IDLE,
        S_COPY
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_copy_src;
    logic          r_avail;
    logic          r_host_ready;
    logic          r_busy;
    logic          r_err;
    logic          r_rd_valid;
    logic [AW-1:0] r_rd_addr;
    logic [RW-1:0] r_rd_row;
    logic          r_host_rvalid;
    logic [RW-1:0] r_host_rdata;

    logic [RW-1:0] r_work [SIZE];
    logic [RW-1:0] r_l    [SIZE];
    logic [RW-1:0] r_u    [SIZE];

    logic          w_wr_acc;
    logic          w_res_acc;
    logic          w_host_conflict;
    logic          w_host_acc;
    logic          w_copy_last;
    logic [RW-1:0] w_rd_row;
    logic [RW-1:0] w_host_row;
    logic [RW-1:0] w_src_row;
    logic [RW-1:0] w_copy_row;

`ifdef ROW_STORE_TRANSPOSE_EN
    logic          r_copy_tr;
    logic [RW-1:0] w_tr_row;
`else
    logic          w_unused_transpose;
    assign w_unused_transpose = copy_transpose_i;
`endif

    // Port arbitration: r_avail is high only in IDLE from the second cycle after reset.
    always_comb begin
        w_wr_acc        = wr_valid_i && r_avail;
        w_res_acc       = res_valid_i && r_avail;
        w_host_conflict = host_we_i &&
                          (((host_sel_i == SEL_WORK) && wr_valid_i) ||
                           (((host_sel_i == SEL_L) || (host_sel_i == SEL_U)) && res_valid_i));
        w_host_acc      = host_req_i && r_avail && !w_host_conflict;
        w_copy_last     = (r_cnt == AW'(SIZE - 1));
    end

    // Read data with write-first forwarding from same-cycle engine/result writes.
    always_comb begin
        w_rd_row = r_work[rd_addr_i];
        if (w_wr_acc && (wr_addr_i == rd_addr_i)) begin
            w_rd_row = wr_row_i;
        end

        w_host_row = '0;
        unique case (host_sel_i)
            SEL_WORK: w_host_row = (w_wr_acc && (wr_addr_i == host_addr_i))
                                   ? wr_row_i : r_work[host_addr_i];
            SEL_L:    w_host_row = (w_res_acc && (res_addr_i == host_addr_i))
                                   ? l_col_i : r_l[host_addr_i];
            SEL_U:    w_host_row = (w_res_acc && (res_addr_i == host_addr_i))
                                   ? u_row_i : r_u[host_addr_i];
            default:  w_host_row = '0;
        endcase
    end

    // Copy source row, optionally gathered column-wise for the transposed copy.
    always_comb begin
        w_src_row  = r_copy_src ? r_u[r_cnt] : r_l[r_cnt];
        w_copy_row = w_src_row;
`ifdef ROW_STORE_TRANSPOSE_EN
        w_tr_row = '0;
        for (int j = 0; j < SIZE; j++) begin
            w_tr_row[j*EW +: EW] = r_copy_src ? r_u[AW'(j)][int'(r_cnt)*EW +: EW]
                                              : r_l[AW'(j)][int'(r_cnt)*EW +: EW];
        end
        if (r_copy_tr) begin
            w_copy_row = w_tr_row;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_copy_src    <= 1'b0;
`ifdef ROW_STORE_TRANSPOSE_EN
            r_copy_tr     <= 1'b0;
`endif
            r_avail       <= 1'b0;
            r_host_ready  <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_row      <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            for (int i = 0; i < SIZE; i++) begin
                r_work[i] <= '0;
                r_l[i]    <= '0;
                r_u[i]    <= '0;
            end
        end else begin
            r_rd_valid    <= 1'b0;
            r_host_rvalid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_wr_acc) begin
                        r_work[wr_addr_i] <= wr_row_i;
                    end
                    if (w_res_acc) begin
                        r_l[res_addr_i] <= l_col_i;
                        r_u[res_addr_i] <= u_row_i;
                    end
                    if (w_host_acc && host_we_i) begin
                        unique case (host_sel_i)
                            SEL_WORK: r_work[host_addr_i] <= host_wdata_i;
                            SEL_L:    r_l[host_addr_i]    <= host_wdata_i;
                            SEL_U:    r_u[host_addr_i]    <= host_wdata_i;
                            default:  r_err               <= 1'b1;
                        endcase
                    end
                    if (w_host_acc && !host_we_i) begin
                        r_host_rvalid <= 1'b1;
                        r_host_rdata  <= w_host_row;
                    end
                    if (rd_addr_valid_i) begin
                        r_rd_valid <= 1'b1;
                        r_rd_addr  <= rd_addr_i;
                        r_rd_row   <= w_rd_row;
                    end
                    if (copy_start_i) begin
                        r_state      <= S_COPY;
                        r_cnt        <= '0;
                        r_copy_src   <= copy_src_i;
`ifdef ROW_STORE_TRANSPOSE_EN
                        r_copy_tr    <= copy_transpose_i;
`endif
                        r_busy       <= 1'b1;
                        r_avail      <= 1'b0;
                        r_host_ready <= 1'b0;
                    end else begin
                        r_avail      <= 1'b1;
                        // Ready reports whether the request just sampled was taken.
                        r_host_ready <= !(host_req_i && w_host_conflict);
                    end
                end
                S_COPY: begin
                    r_work[r_cnt] <= w_copy_row;
                    if (rd_addr_valid_i) begin
                        r_err <= 1'b1;
                    end
                    if (w_copy_last) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_avail      <= 1'b1;
                        r_host_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_row_o      = r_rd_row;
    assign rd_addr_o     = r_rd_addr;
    assign rd_valid_o    = r_rd_valid;
    assign wr_ready_o    = r_avail;
    assign res_ready_o   = r_avail;
    assign host_ready_o  = r_host_ready;
    assign host_rdata_o  = r_host_rdata;
    assign host_rvalid_o = r_host_rvalid;
    assign busy_o        = r_busy;
    assign err_o         = r_err;

endmodule

// File: tb/tb_matrix_row_store.sv
// Directed bench for matrix_row_store (SIZE=4, WIDTH=64); follows ROW_STORE_TRANSPOSE_EN.
module tb_matrix_row_store;

    localparam int unsigned SIZE  = 4;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned AW    = 2;
    localparam int unsigned EW    = 2 * WIDTH;
    localparam int unsigned RW    = SIZE * EW;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rd_addr;
    logic          rd_addr_valid;
    logic [RW-1:0] rd_row_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_valid_o;
    logic [RW-1:0] wr_row;
    logic [AW-1:0] wr_addr;
    logic          wr_valid;
    logic          wr_ready_o;
    logic [RW-1:0] l_col;
    logic [RW-1:0] u_row;
    logic [AW-1:0] res_addr;
    logic          res_valid;
    logic          res_ready_o;
    logic          host_req;
    logic          host_we;
    logic [1:0]    host_sel;
    logic [AW-1:0] host_addr;
    logic [RW-1:0] host_wdata;
    logic          host_ready_o;
    logic [RW-1:0] host_rdata_o;
    logic          host_rvalid_o;
    logic          copy_start;
    logic          copy_src;
    logic          copy_transpose;
    logic          busy_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_addr_i(rd_addr), .rd_addr_valid_i(rd_addr_valid),
        .rd_row_o(rd_row_o), .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o),
        .wr_row_i(wr_row), .wr_addr_i(wr_addr), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
        .l_col_i(l_col), .u_row_i(u_row), .res_addr_i(res_addr), .res_valid_i(res_valid),
        .res_ready_o(res_ready_o),
        .host_req_i(host_req), .host_we_i(host_we), .host_sel_i(host_sel),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_ready_o(host_ready_o),
        .host_rdata_o(host_rdata_o), .host_rvalid_o(host_rvalid_o),
        .copy_start_i(copy_start), .copy_src_i(copy_src), .copy_transpose_i(copy_transpose),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] fill8(input logic [7:0] b);
        fill8 = {(RW/8){b}};
    endfunction

    function automatic logic [RW-1:0] real_row(input logic [63:0] re);
        logic [RW-1:0] r;
        r = '0;
        for (int j = 0; j < SIZE; j++) r[j*EW +: EW] = {64'h0, re};
        return r;
    endfunction

    // Upper-triangular test matrix: element (i,j) = {imag i*4+j+256, real i*4+j}, zero below diagonal.
    function automatic logic [EW-1:0] tri_elem(input int i, input int j);
        if (j >= i) tri_elem = {64'(i*4 + j + 256), 64'(i*4 + j)};
        else        tri_elem = '0;
    endfunction

    function automatic logic [RW-1:0] tri_row(input int i);
        logic [RW-1:0] r;
        for (int j = 0; j < SIZE; j++) r[j*EW +: EW] = tri_elem(i, j);
        return r;
    endfunction

    function automatic logic [RW-1:0] copy_expect(input int r);
        logic [RW-1:0] x;
        for (int j = 0; j < SIZE; j++) begin
`ifdef ROW_STORE_TRANSPOSE_EN
            x[j*EW +: EW] = tri_elem(j, r);
`else
            x[j*EW +: EW] = tri_elem(r, j);
`endif
        end
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic host_op(input logic we, input logic [1:0] sel, input logic [AW-1:0] addr,
                           input logic [RW-1:0] wd, output logic rdy, output logic [RW-1:0] rdata,
                           output logic rv);
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_sel = sel; host_addr = addr; host_wdata = wd;
        @(posedge clk); #1;
        rdy = host_ready_o; rdata = host_rdata_o; rv = host_rvalid_o;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic engine_read(input logic [AW-1:0] addr, output logic v,
                               output logic [RW-1:0] row, output logic [AW-1:0] a);
        @(negedge clk);
        rd_addr_valid = 1'b1; rd_addr = addr;
        @(posedge clk); #1;
        v = rd_valid_o; row = rd_row_o; a = rd_addr_o;
        rd_addr_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({rd_valid_o, wr_ready_o, res_ready_o, host_ready_o, host_rvalid_o, busy_o, err_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b exp 0000000",
                     {rd_valid_o, wr_ready_o, res_ready_o, host_ready_o, host_rvalid_o, busy_o, err_o});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({wr_ready_o, res_ready_o, host_ready_o, busy_o, err_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL post_reset_cycle: got %b exp 00000",
                     {wr_ready_o, res_ready_o, host_ready_o, busy_o, err_o});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({wr_ready_o, res_ready_o, host_ready_o, busy_o} !== 4'b1110) begin
            n_fail++;
            $display("FAIL ready_rise: got %b exp 1110", {wr_ready_o, res_ready_o, host_ready_o, busy_o});
        end
    endtask

    task automatic test_read();
        logic rdy, rv, v;
        logic [RW-1:0] hd, row, held;
        logic [AW-1:0] a;
        host_op(1'b1, 2'd0, 2'd2, fill8(8'hA5), rdy, hd, rv);
        n_checks++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL host_write_ready: got %b exp 1", rdy); end
        engine_read(2'd2, v, row, a);
        n_checks++;
        if (v !== 1'b1 || a !== 2'd2 || row !== fill8(8'hA5)) begin
            n_fail++;
            $display("FAIL read_row2: valid %b addr %0d data %h exp 1 2 %h", v, a, row, fill8(8'hA5));
        end
        held = row;
        @(posedge clk); #1;
        n_checks++;
        if (rd_valid_o !== 1'b0 || rd_row_o !== held || rd_addr_o !== 2'd2) begin
            n_fail++;
            $display("FAIL read_hold: valid %b data %h exp 0 %h", rd_valid_o, rd_row_o, held);
        end
        do_reset();
        engine_read(2'd2, v, row, a);
        n_checks++;
        if (v !== 1'b1 || row !== '0) begin
            n_fail++;
            $display("FAIL read_after_reset: valid %b data %h exp 1 0", v, row);
        end
    endtask

    task automatic test_forward();
        logic rdy, rv;
        logic [RW-1:0] hd;
        logic [RW-1:0] exp_rows [SIZE];
        exp_rows[0] = fill8(8'h11); exp_rows[1] = fill8(8'h3C);
        exp_rows[2] = fill8(8'h22); exp_rows[3] = fill8(8'h33);
        host_op(1'b1, 2'd0, 2'd0, fill8(8'h11), rdy, hd, rv);
        host_op(1'b1, 2'd0, 2'd2, fill8(8'h22), rdy, hd, rv);
        host_op(1'b1, 2'd0, 2'd3, fill8(8'h33), rdy, hd, rv);
        @(negedge clk);
        rd_addr_valid = 1'b1; rd_addr = 2'd1;
        wr_valid = 1'b1; wr_addr = 2'd1; wr_row = fill8(8'h3C);
        @(posedge clk); #1;
        rd_addr_valid = 1'b0; wr_valid = 1'b0;
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_row_o !== fill8(8'h3C)) begin
            n_fail++;
            $display("FAIL forward: valid %b data %h exp 1 %h", rd_valid_o, rd_row_o, fill8(8'h3C));
        end
        for (int k = 0; k < SIZE; k++) begin
            @(negedge clk);
            rd_addr_valid = 1'b1; rd_addr = AW'(k);
            @(posedge clk); #1;
            n_checks++;
            if (rd_valid_o !== 1'b1 || rd_addr_o !== AW'(k) || rd_row_o !== exp_rows[k]) begin
                n_fail++;
                $display("FAIL stream_%0d: valid %b addr %0d data %h exp %h",
                         k, rd_valid_o, rd_addr_o, rd_row_o, exp_rows[k]);
            end
        end
        @(negedge clk);
        rd_addr_valid = 1'b0;
    endtask

    task automatic test_result();
        logic rdy, rv;
        logic [RW-1:0] hd;
        @(negedge clk);
        res_valid = 1'b1; res_addr = 2'd3;
        l_col = real_row(64'h3FF0000000000000); u_row = real_row(64'h4000000000000000);
        host_req = 1'b1; host_we = 1'b1; host_sel = 2'd1; host_addr = 2'd0; host_wdata = fill8(8'hEE);
        @(posedge clk); #1;
        res_valid = 1'b0; host_req = 1'b0; host_we = 1'b0;
        n_checks++;
        if (host_ready_o !== 1'b0 || res_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL host_refused: host_ready %b res_ready %b exp 0 1", host_ready_o, res_ready_o);
        end
        host_op(1'b0, 2'd1, 2'd3, '0, rdy, hd, rv);
        n_checks++;
        if (rdy !== 1'b1 || rv !== 1'b1 || hd !== real_row(64'h3FF0000000000000)) begin
            n_fail++;
            $display("FAIL read_L3: ready %b rvalid %b data %h", rdy, rv, hd);
        end
        @(posedge clk); #1;
        n_checks++;
        if (host_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rvalid_pulse: got %b exp 0", host_rvalid_o);
        end
        host_op(1'b0, 2'd2, 2'd3, '0, rdy, hd, rv);
        n_checks++;
        if (rv !== 1'b1 || hd !== real_row(64'h4000000000000000)) begin
            n_fail++;
            $display("FAIL read_U3: rvalid %b data %h", rv, hd);
        end
        host_op(1'b0, 2'd1, 2'd0, '0, rdy, hd, rv);
        n_checks++;
        if (rv !== 1'b1 || hd !== '0) begin
            n_fail++;
            $display("FAIL refused_write_L0: rvalid %b data %h exp 0", rv, hd);
        end
    endtask

    task automatic test_copy();
        logic rdy, rv, v;
        logic [RW-1:0] hd, row;
        logic [AW-1:0] a;
        int busy_cnt;
        for (int i = 0; i < SIZE; i++) host_op(1'b1, 2'd1, AW'(i), tri_row(i), rdy, hd, rv);
        @(negedge clk);
        copy_start = 1'b1; copy_src = 1'b0; copy_transpose = 1'b1;
        @(posedge clk); #1;
        copy_start = 1'b0; copy_transpose = 1'b0;
        busy_cnt = busy_o ? 1 : 0;
        n_checks++;
        if (wr_ready_o !== 1'b0 || host_ready_o !== 1'b0 || res_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL readies_in_copy: got %b%b%b exp 000", wr_ready_o, res_ready_o, host_ready_o);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (busy_o) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != SIZE) begin
            n_fail++;
            $display("FAIL busy_cycles: got %0d exp %0d", busy_cnt, SIZE);
        end
        for (int r = 0; r < SIZE; r++) begin
            engine_read(AW'(r), v, row, a);
            n_checks++;
            if (v !== 1'b1 || row !== copy_expect(r)) begin
                n_fail++;
                $display("FAIL copy_row_%0d: valid %b data %h exp %h", r, v, row, copy_expect(r));
            end
        end
    endtask

    task automatic test_illegal();
        logic rdy, rv;
        logic [RW-1:0] hd;
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b exp 0", err_o); end
        @(negedge clk);
        copy_start = 1'b1; copy_src = 1'b1;
        @(negedge clk);
        copy_start = 1'b0;
        @(negedge clk);
        rd_addr_valid = 1'b1; rd_addr = 2'd1;
        @(posedge clk); #1;
        rd_addr_valid = 1'b0;
        n_checks++;
        if (rd_valid_o !== 1'b0 || err_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL read_in_copy: rd_valid %b err %b busy %b exp 0 1 1", rd_valid_o, err_o, busy_o);
        end
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: err %b busy %b exp 1 0", err_o, busy_o);
        end
        do_reset();
        host_op(1'b1, 2'd3, 2'd0, fill8(8'hFF), rdy, hd, rv);
        n_checks++;
        if (rdy !== 1'b1 || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sel3_write: ready %b err %b exp 1 1", rdy, err_o);
        end
        for (int s = 0; s < 3; s++) begin
            host_op(1'b0, 2'(s), 2'd0, '0, rdy, hd, rv);
            n_checks++;
            if (rv !== 1'b1 || hd !== '0) begin
                n_fail++;
                $display("FAIL sel3_no_store_bank%0d: rvalid %b data %h exp 0", s, rv, hd);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        logic rdy, rv;
        logic [RW-1:0] hd;
        host_op(1'b1, 2'd1, 2'd1, fill8(8'h77), rdy, hd, rv);
        host_op(1'b1, 2'd2, 2'd1, fill8(8'h66), rdy, hd, rv);
        host_op(1'b1, 2'd0, 2'd2, fill8(8'h55), rdy, hd, rv);
        @(negedge clk);
        copy_start = 1'b1; copy_src = 1'b0;
        @(negedge clk);
        copy_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_after_reset: got %b exp 0", busy_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int r = 1; r < 3; r++) begin
                host_op(1'b0, 2'(s), AW'(r), '0, rdy, hd, rv);
                n_checks++;
                if (rv !== 1'b1 || hd !== '0) begin
                    n_fail++;
                    $display("FAIL midcopy_clear_bank%0d_row%0d: rvalid %b data %h exp 0", s, r, rv, hd);
                end
            end
        end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b exp 0", busy_o); end
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; rd_addr_valid = 1'b0;
        wr_row = '0; wr_addr = '0; wr_valid = 1'b0;
        l_col = '0; u_row = '0; res_addr = '0; res_valid = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_sel = '0; host_addr = '0; host_wdata = '0;
        copy_start = 1'b0; copy_src = 1'b0; copy_transpose = 1'b0;
        test_reset();
        test_read();
        test_forward();
        test_result();
        test_copy();
        test_illegal();
        test_reset_mid_copy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
